// File: rtl/dsp_reset_sequencer.sv
// C6678 reset-pin sequencer: POR# -> RESETFULL#/RESET# -> RESETSTAT# check,
// with debounced full/warm reset buttons and power-good supervision.
`timescale 1ns/1ps

module dsp_rst_debounce #(
    parameter logic [7:0] DEB_LEN = 8'd200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_s,
    output logic press
);
    localparam logic [7:0] DEB_EFF = (DEB_LEN == 8'd0) ? 8'd1 : DEB_LEN;

    logic [7:0] cnt;

    // Counter saturates, so a held button yields exactly one event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (btn_s)
            cnt <= '0;
        else if (cnt != DEB_EFF)
            cnt <= cnt + 8'd1;
    end

    assign press = !btn_s && (cnt == DEB_EFF - 8'd1);
endmodule

module dsp_reset_sequencer #(
    parameter logic [15:0] POR_DELAY    = 16'd1000,
    parameter logic [15:0] FULL_DELAY   = 16'd500,
    parameter logic [15:0] WARM_PULSE   = 16'd100,
    parameter logic [7:0]  DEB_LEN      = 8'd200,
    parameter logic [15:0] STAT_TIMEOUT = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwr_good,
    input  logic full_rst_btn_n,
    input  logic warm_rst_btn_n,
    input  logic dsp_resetstat_n,
    output logic dsp_por_n,
    output logic dsp_resetfull_n,
    output logic dsp_reset_n,
    output logic bootmode_oe,
    output logic seq_done,
    output logic seq_err
);
    typedef enum logic [2:0] {
        S_WAIT_PG, S_POR_ASSERT, S_FULL_ASSERT, S_WAIT_STAT,
        S_RUN, S_WARM_ASSERT, S_ERROR
    } state_t;

    localparam logic [15:0] POR_D  = (POR_DELAY    == 16'd0) ? 16'd1 : POR_DELAY;
    localparam logic [15:0] FULL_D = (FULL_DELAY   == 16'd0) ? 16'd1 : FULL_DELAY;
    localparam logic [15:0] WARM_D = (WARM_PULSE   == 16'd0) ? 16'd1 : WARM_PULSE;
    localparam logic [15:0] STAT_D = (STAT_TIMEOUT == 16'd0) ? 16'd1 : STAT_TIMEOUT;

    logic [1:0]  pg_sync, full_sync, warm_sync, stat_sync;
    logic        pg_s, stat_s;
    logic [1:0]  btn_s, press;
    logic        full_press, warm_press;
    state_t      state, next_state;
    logic [15:0] cnt;
    logic        restart;
    logic        por_d, resetfull_d, reset_d, oe_d, done_d, err_d;

    // Buttons and RESETSTAT# idle high; power-good is assumed absent until seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pg_sync   <= 2'b00;
            full_sync <= 2'b11;
            warm_sync <= 2'b11;
            stat_sync <= 2'b11;
        end else begin
            pg_sync   <= {pg_sync[0], pwr_good};
            full_sync <= {full_sync[0], full_rst_btn_n};
            warm_sync <= {warm_sync[0], warm_rst_btn_n};
            stat_sync <= {stat_sync[0], dsp_resetstat_n};
        end
    end

    assign pg_s   = pg_sync[1];
    assign stat_s = stat_sync[1];
    assign btn_s  = {warm_sync[1], full_sync[1]};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_deb
            dsp_rst_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .btn_s (btn_s[g]),
                .press (press[g])
            );
        end
    endgenerate

    assign full_press = press[0];
    assign warm_press = press[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_WAIT_PG;
            cnt             <= '0;
            dsp_por_n       <= 1'b0;
            dsp_resetfull_n <= 1'b0;
            dsp_reset_n     <= 1'b0;
            bootmode_oe     <= 1'b1;
            seq_done        <= 1'b0;
            seq_err         <= 1'b0;
        end else begin
            state           <= next_state;
            cnt             <= restart ? 16'd0 : ((&cnt) ? cnt : cnt + 16'd1);
            dsp_por_n       <= por_d;
            dsp_resetfull_n <= resetfull_d;
            dsp_reset_n     <= reset_d;
            bootmode_oe     <= oe_d;
            seq_done        <= done_d;
            seq_err         <= err_d;
        end
    end

    // A full press re-enters FULL_ASSERT even from FULL_ASSERT, restarting its delay.
    always_comb begin
        next_state = state;
        restart    = 1'b0;
        if (!pg_s) begin
            next_state = S_WAIT_PG;
            restart    = 1'b1;
        end else if (full_press && state != S_WAIT_PG && state != S_POR_ASSERT) begin
            next_state = S_FULL_ASSERT;
            restart    = 1'b1;
        end else begin
            case (state)
                S_WAIT_PG:     next_state = S_POR_ASSERT;
                S_POR_ASSERT:  if (cnt == POR_D - 16'd1)  next_state = S_FULL_ASSERT;
                S_FULL_ASSERT: if (cnt == FULL_D - 16'd1) next_state = S_WAIT_STAT;
                S_WAIT_STAT: begin
                    if (stat_s)
                        next_state = S_RUN;
                    else if (cnt == STAT_D - 16'd1)
                        next_state = S_ERROR;
                end
                S_RUN:         if (warm_press) next_state = S_WARM_ASSERT;
                S_WARM_ASSERT: if (cnt == WARM_D - 16'd1) next_state = S_WAIT_STAT;
                S_ERROR:       next_state = S_ERROR;
                default:       next_state = S_WAIT_PG;
            endcase
            restart = (next_state != state);
        end
    end

    // Outputs decode the state being entered so pins change on the same edge.
    always_comb begin
        por_d       = 1'b0;
        resetfull_d = 1'b0;
        reset_d     = 1'b0;
        oe_d        = 1'b1;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (next_state)
            S_FULL_ASSERT: por_d = 1'b1;
            S_WAIT_STAT: begin
                por_d       = 1'b1;
                resetfull_d = 1'b1;
                reset_d     = 1'b1;
            end
            S_RUN: begin
                por_d       = 1'b1;
                resetfull_d = 1'b1;
                reset_d     = 1'b1;
                oe_d        = 1'b0;
                done_d      = 1'b1;
            end
            S_WARM_ASSERT: begin
                por_d       = 1'b1;
                resetfull_d = 1'b1;
            end
            S_ERROR: begin
                por_d       = 1'b1;
                resetfull_d = 1'b1;
                reset_d     = 1'b1;
                err_d       = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dsp_reset_sequencer.sv
// Bench for dsp_reset_sequencer: directed vector table, reset-through-press
// sequence, then random stimulus against a countdown-based phase model.
`timescale 1ns/1ps

module tb_dsp_reset_sequencer;
    localparam int POR_D = 10, FULL_D = 6, WARM_D = 4, DEB = 3, STAT_D = 20;

    // {por_n, resetfull_n, reset_n, bootmode_oe, seq_done, seq_err}
    localparam logic [5:0] O_LOW  = 6'b000100;
    localparam logic [5:0] O_FULL = 6'b100100;
    localparam logic [5:0] O_WST  = 6'b111100;
    localparam logic [5:0] O_RUN  = 6'b111010;
    localparam logic [5:0] O_WARM = 6'b110100;
    localparam logic [5:0] O_ERR  = 6'b111101;

    localparam int P_WPG = 0, P_POR = 1, P_FULL = 2, P_WST = 3, P_RUN = 4, P_WARM = 5, P_ERR = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwr_good = 1'b0;
    logic full_rst_btn_n = 1'b1;
    logic warm_rst_btn_n = 1'b1;
    logic dsp_resetstat_n = 1'b0;
    logic dsp_por_n, dsp_resetfull_n, dsp_reset_n, bootmode_oe, seq_done, seq_err;
    logic [5:0] obs;

    dsp_reset_sequencer #(
        .POR_DELAY(16'd10), .FULL_DELAY(16'd6), .WARM_PULSE(16'd4),
        .DEB_LEN(8'd3), .STAT_TIMEOUT(16'd20)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pwr_good        (pwr_good),
        .full_rst_btn_n  (full_rst_btn_n),
        .warm_rst_btn_n  (warm_rst_btn_n),
        .dsp_resetstat_n (dsp_resetstat_n),
        .dsp_por_n       (dsp_por_n),
        .dsp_resetfull_n (dsp_resetfull_n),
        .dsp_reset_n     (dsp_reset_n),
        .bootmode_oe     (bootmode_oe),
        .seq_done        (seq_done),
        .seq_err         (seq_err)
    );

    always #5 clk = ~clk;

    assign obs = {dsp_por_n, dsp_resetfull_n, dsp_reset_n, bootmode_oe, seq_done, seq_err};

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       rst;
        logic       pg;
        logic       fb;
        logic       wb;
        logic       st;
        int         hold;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic r, input logic p, input logic f, input logic w,
                        input logic s, input int h, input logic [5:0] e);
        vec_t v;
        v.rst = r; v.pg = p; v.fb = f; v.wb = w; v.st = s; v.hold = h; v.exp = e;
        vecs.push_back(v);
    endtask

    // Reference model: phases with a remaining-cycle countdown, inputs delayed
    // two samples, button presses as a run length of low samples.
    int m_phase, m_left, frun, wrun;
    logic [1:0] pgd, fd, wd, sd;

    function automatic int dur(input int p);
        case (p)
            P_POR:   return POR_D;
            P_FULL:  return FULL_D;
            P_WST:   return STAT_D;
            P_WARM:  return WARM_D;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] exp_of(input int p);
        case (p)
            P_FULL:  return O_FULL;
            P_WST:   return O_WST;
            P_RUN:   return O_RUN;
            P_WARM:  return O_WARM;
            P_ERR:   return O_ERR;
            default: return O_LOW;
        endcase
    endfunction

    task automatic enter(input int p);
        m_phase = p;
        m_left  = dur(p);
    endtask

    task automatic model_reset();
        pgd = 2'b00; fd = 2'b11; wd = 2'b11; sd = 2'b11;
        frun = 0; wrun = 0;
        enter(P_WPG);
    endtask

    task automatic model_step();
        logic fe, we;
        frun = (fd[1] == 1'b0) ? frun + 1 : 0;
        wrun = (wd[1] == 1'b0) ? wrun + 1 : 0;
        fe = (frun == DEB);
        we = (wrun == DEB);
        if (!pgd[1])
            enter(P_WPG);
        else if (fe && m_phase != P_WPG && m_phase != P_POR)
            enter(P_FULL);
        else begin
            case (m_phase)
                P_WPG:  enter(P_POR);
                P_POR:  if (m_left == 1) enter(P_FULL); else m_left--;
                P_FULL: if (m_left == 1) enter(P_WST);  else m_left--;
                P_WST: begin
                    if (sd[1]) enter(P_RUN);
                    else if (m_left == 1) enter(P_ERR);
                    else m_left--;
                end
                P_RUN:  if (we) enter(P_WARM);
                P_WARM: if (m_left == 1) enter(P_WST); else m_left--;
                default: ;
            endcase
        end
        pgd = {pgd[0], pwr_good};
        fd  = {fd[0], full_rst_btn_n};
        wd  = {wd[0], warm_rst_btn_n};
        sd  = {sd[0], dsp_resetstat_n};
    endtask

    task automatic rst_pulse();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check("rnd_reset", obs, exp_of(m_phase));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        logic inv;

        // rst, pg, full_n, warm_n, stat_n, cycles, expected
        addv(0,0,1,1,0, 2, O_LOW);   // reset values
        addv(1,0,1,1,0, 3, O_LOW);
        addv(1,1,1,1,0,12, O_LOW);   // cold boot: POR held 10 cycles
        addv(1,1,1,1,0, 1, O_FULL);
        addv(1,1,1,1,0, 5, O_FULL);
        addv(1,1,1,1,0, 1, O_WST);
        addv(1,1,1,1,1, 2, O_WST);
        addv(1,1,1,1,1, 1, O_RUN);
        addv(1,1,1,0,1, 2, O_RUN);   // 2-cycle warm glitch
        addv(1,1,1,1,1, 6, O_RUN);
        addv(1,1,1,0,1, 3, O_RUN);   // warm press
        addv(1,1,1,1,1, 1, O_RUN);
        addv(1,1,1,1,1, 1, O_WARM);
        addv(1,1,1,1,1, 3, O_WARM);
        addv(1,1,1,1,1, 1, O_WST);
        addv(1,1,1,1,1, 1, O_RUN);
        addv(1,1,0,0,1, 3, O_RUN);   // full + warm together
        addv(1,1,1,1,1, 1, O_RUN);
        addv(1,1,1,1,1, 1, O_FULL);
        addv(1,1,1,1,1, 5, O_FULL);
        addv(1,1,1,1,1, 1, O_WST);
        addv(1,1,1,1,1, 1, O_RUN);
        addv(1,1,0,1,0, 3, O_RUN);   // full press, stat held low
        addv(1,1,1,1,0, 1, O_RUN);
        addv(1,1,1,1,0, 1, O_FULL);
        addv(1,1,1,1,0, 6, O_WST);
        addv(1,1,1,1,0,19, O_WST);
        addv(1,1,1,1,0, 1, O_ERR);   // timeout 20 cycles after entry
        addv(1,1,0,1,0, 3, O_ERR);
        addv(1,1,1,1,0, 1, O_ERR);
        addv(1,1,1,1,0, 1, O_FULL);  // full press leaves ERROR
        addv(1,0,1,1,0, 2, O_FULL);  // power loss mid FULL_ASSERT
        addv(1,0,1,1,0, 1, O_LOW);
        addv(1,1,1,1,1,12, O_LOW);
        addv(1,1,1,1,1, 1, O_FULL);
        addv(1,1,1,1,1, 5, O_FULL);
        addv(1,1,1,1,1, 1, O_WST);
        addv(1,1,1,1,1, 1, O_RUN);
        addv(1,0,1,1,1, 2, O_RUN);   // power loss in RUN
        addv(1,0,1,1,1, 1, O_LOW);
        addv(1,1,1,1,1, 3, O_LOW);
        addv(1,1,1,1,1,16, O_WST);
        addv(1,1,1,1,1, 1, O_RUN);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n           = vecs[i].rst;
            pwr_good        = vecs[i].pg;
            full_rst_btn_n  = vecs[i].fb;
            warm_rst_btn_n  = vecs[i].wb;
            dsp_resetstat_n = vecs[i].st;
            repeat (vecs[i].hold) tick();
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // rst_n during WARM_ASSERT with the warm button held through release
        warm_rst_btn_n = 1'b0;
        repeat (5) tick();
        check("warm_before_rst", obs, O_WARM);
        #2 rst_n = 1'b0;
        #1 check("async_rst", obs, O_LOW);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (19) tick();
        check("rerun_wait_stat", obs, O_WST);
        tick();
        check("rerun_run", obs, O_RUN);
        repeat (10) tick();
        check("held_btn_single_event", obs, O_RUN);
        warm_rst_btn_n = 1'b1;
        repeat (6) tick();
        check("after_btn_release", obs, O_RUN);

        // randomized run against the model
        pwr_good = 1'b1; full_rst_btn_n = 1'b1; warm_rst_btn_n = 1'b1; dsp_resetstat_n = 1'b1;
        rst_pulse();
        for (int s = 0; s < 400; s++) begin
            pwr_good        = ($urandom_range(0, 24) != 0);
            full_rst_btn_n  = ($urandom_range(0, 5) != 0);
            warm_rst_btn_n  = ($urandom_range(0, 3) != 0);
            dsp_resetstat_n = ($urandom_range(0, 2) != 0);
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 6));
            for (int c = 0; c < len; c++) begin
                @(posedge clk);
                model_step();
                @(negedge clk);
                check("rnd_model", obs, exp_of(m_phase));
                inv = (dsp_por_n | (~dsp_resetfull_n & ~dsp_reset_n))
                    & (dsp_resetfull_n | ~dsp_reset_n)
                    & (dsp_resetfull_n | bootmode_oe);
                check("rnd_invariants", {5'b0, inv}, 6'd1);
            end
            if ($urandom_range(0, 79) == 0)
                rst_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
